// File: rtl/r2b_pkg.sv
// r2b_pkg: shared types and index helpers for the row-to-block converter.
package r2b_pkg;

   typedef enum logic {
      FILL  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   function automatic int blocks_per_band(input int col, input int bs);
      return col / bs;
   endfunction

   function automatic int beats_per_matrix(input int row, input int col,
                                           input int bs, input int nc);
      return ((row / bs) * (col / bs)) / nc;
   endfunction

   function automatic int lane_off(input int l, input int e,
                                   input int chunk, input int width);
      return (l * chunk + e) * width;
   endfunction

   function automatic int src_row(input int blk, input int e,
                                  input int col, input int bs);
      return (blk / blocks_per_band(col, bs)) * bs + e / bs;
   endfunction

   function automatic int src_col(input int blk, input int e,
                                  input int col, input int bs);
      return (blk % blocks_per_band(col, bs)) * bs + e % bs;
   endfunction

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/r2b_bank.sv
// r2b_bank: ROW x COL element store, one row written per cycle,
// one block-ordered beat gathered combinationally per read index.
module r2b_bank
   import r2b_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int ROW        = 8,
   parameter int COL        = 6,
   parameter int BLOCK_SIZE = 2,
   parameter int CHUNK_SIZE = 4,
   parameter int NUM_CORES  = 2,
   localparam int BEATS = beats_per_matrix(ROW, COL, BLOCK_SIZE, NUM_CORES),
   localparam int RW    = cnt_w(ROW),
   localparam int BW    = cnt_w(BEATS),
   localparam int IW    = WIDTH * COL,
   localparam int OW    = WIDTH * CHUNK_SIZE * NUM_CORES
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we_i,
   input  logic [RW-1:0] wrow_i,
   input  logic [IW-1:0] wdata_i,
   input  logic [BW-1:0] rbeat_i,
   output logic [OW-1:0] rdata_o
);

   logic [IW-1:0] mem_q [ROW];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < ROW; r++) mem_q[r] <= '0;
      end else if (we_i) begin
         mem_q[wrow_i] <= wdata_i;
      end
   end

   // Every output element is a static mux over beats of fixed cells.
   for (genvar l = 0; l < NUM_CORES; l++) begin : g_lane
      for (genvar e = 0; e < CHUNK_SIZE; e++) begin : g_elem
         logic [WIDTH-1:0] cand [BEATS];
         for (genvar k = 0; k < BEATS; k++) begin : g_beat
            localparam int BLK = k * NUM_CORES + l;
            localparam int SR  = src_row(BLK, e, COL, BLOCK_SIZE);
            localparam int SC  = src_col(BLK, e, COL, BLOCK_SIZE);
            assign cand[k] = mem_q[SR][SC*WIDTH +: WIDTH];
         end
         assign rdata_o[lane_off(l, e, CHUNK_SIZE, WIDTH) +: WIDTH] =
            cand[rbeat_i];
      end
   end

endmodule

// File: rtl/r2b_converter.sv
// r2b_converter: row-major matrix in, block-ordered multi-core beats out.
// Define R2B_DBUF_EN for two ping-pong banks (fill overlaps drain).
module r2b_converter
   import r2b_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int FRAC_WIDTH = 8,
   parameter int ROW        = 8,
   parameter int COL        = 6,
   parameter int BLOCK_SIZE = 2,
   parameter int CHUNK_SIZE = 4,
   parameter int NUM_CORES  = 2,
   localparam int IW = WIDTH * COL,
   localparam int OW = WIDTH * CHUNK_SIZE * NUM_CORES
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [IW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [OW-1:0] out_data,
   output logic          done
);

   localparam int BEATS = beats_per_matrix(ROW, COL, BLOCK_SIZE, NUM_CORES);
   localparam int RW    = cnt_w(ROW);
   localparam int BW    = cnt_w(BEATS);
   localparam logic [RW-1:0] ROW_LAST  = RW'(ROW - 1);
   localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);

   if (CHUNK_SIZE != BLOCK_SIZE * BLOCK_SIZE || FRAC_WIDTH > WIDTH) begin : g_cfg_err
      $error("r2b_converter: inconsistent parameters");
   end

   logic [RW-1:0] row_q, row_d;
   logic [BW-1:0] beat_q, beat_d;
   logic          done_q, done_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_q  <= '0;
         beat_q <= '0;
         done_q <= 1'b0;
      end else begin
         row_q  <= row_d;
         beat_q <= beat_d;
         done_q <= done_d;
      end
   end

   assign done = done_q;

`ifdef R2B_DBUF_EN
   state_t        st_q [2];
   state_t        st_d [2];
   logic          wr_q, wr_d, rd_q, rd_d;
   logic [1:0]    we;
   logic [OW-1:0] rdata [2];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q[0] <= FILL;
         st_q[1] <= FILL;
         wr_q    <= 1'b0;
         rd_q    <= 1'b0;
      end else begin
         st_q <= st_d;
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   // Write and read pointers always address different banks when both act.
   always_comb begin
      st_d      = st_q;
      wr_d      = wr_q;
      rd_d      = rd_q;
      row_d     = row_q;
      beat_d    = beat_q;
      done_d    = 1'b0;
      we        = '0;
      in_ready  = en && (st_q[wr_q] == FILL);
      out_valid = en && (st_q[rd_q] == DRAIN);
      if (in_ready && in_valid) begin
         we[wr_q] = 1'b1;
         row_d    = row_q + 1'b1;
         if (row_q == ROW_LAST) begin
            row_d       = '0;
            st_d[wr_q]  = DRAIN;
            wr_d        = ~wr_q;
         end
      end
      if (out_valid && out_ready) begin
         beat_d = beat_q + 1'b1;
         if (beat_q == BEAT_LAST) begin
            beat_d      = '0;
            st_d[rd_q]  = FILL;
            rd_d        = ~rd_q;
            done_d      = 1'b1;
         end
      end
   end

   for (genvar g = 0; g < 2; g++) begin : g_bank
      r2b_bank #(
         .WIDTH(WIDTH), .ROW(ROW), .COL(COL), .BLOCK_SIZE(BLOCK_SIZE),
         .CHUNK_SIZE(CHUNK_SIZE), .NUM_CORES(NUM_CORES)
      ) u_bank (
         .clk     (clk),
         .rst     (rst),
         .we_i    (we[g]),
         .wrow_i  (row_q),
         .wdata_i (in_data),
         .rbeat_i (beat_q),
         .rdata_o (rdata[g])
      );
   end

   assign out_data = rdata[rd_q];
`else
   state_t st_q, st_d;
   logic   we;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) st_q <= FILL;
      else     st_q <= st_d;
   end

   always_comb begin
      st_d      = st_q;
      row_d     = row_q;
      beat_d    = beat_q;
      done_d    = 1'b0;
      we        = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (st_q)
         FILL: begin
            in_ready = en;
            if (in_valid && en) begin
               we    = 1'b1;
               row_d = row_q + 1'b1;
               if (row_q == ROW_LAST) begin
                  row_d = '0;
                  st_d  = DRAIN;
               end
            end
         end
         DRAIN: begin
            out_valid = en;
            if (out_ready && en) begin
               beat_d = beat_q + 1'b1;
               if (beat_q == BEAT_LAST) begin
                  beat_d = '0;
                  st_d   = FILL;
                  done_d = 1'b1;
               end
            end
         end
      endcase
   end

   r2b_bank #(
      .WIDTH(WIDTH), .ROW(ROW), .COL(COL), .BLOCK_SIZE(BLOCK_SIZE),
      .CHUNK_SIZE(CHUNK_SIZE), .NUM_CORES(NUM_CORES)
   ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .we_i    (we),
      .wrow_i  (row_q),
      .wdata_i (in_data),
      .rbeat_i (beat_q),
      .rdata_o (out_data)
   );
`endif

endmodule

// File: tb/tb_r2b_converter.sv
// tb_r2b_converter: directed matrices against a block-reordering scoreboard,
// plus literal beats for the reference matrix.
module tb_r2b_converter;

   localparam int W     = 16;
   localparam int ROW   = 8;
   localparam int COL   = 6;
   localparam int BS    = 2;
   localparam int CH    = 4;
   localparam int NC    = 2;
   localparam int BEATS = 6;
   localparam int IW    = W * COL;
   localparam int OW    = W * CH * NC;

   logic          clk = 1'b0;
   logic          rst, en, in_valid, in_ready, out_valid, out_ready, done;
   logic [IW-1:0] in_data;
   logic [OW-1:0] out_data;

   r2b_converter #(
      .WIDTH(W), .FRAC_WIDTH(8), .ROW(ROW), .COL(COL),
      .BLOCK_SIZE(BS), .CHUNK_SIZE(CH), .NUM_CORES(NC)
   ) dut (
      .clk(clk), .rst(rst), .en(en),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .done(done)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int beats_seen = 0;
   int done_cnt = 0;
   int or_mode = 0;
   int last_acc = 0;

   typedef struct {
      logic [OW-1:0] d;
      bit            last;
   } exp_t;

   exp_t          exp_q [$];
   logic [OW-1:0] log_d [$];
   int            log_c [$];
   bit            exp_done = 0;
   bit            stall = 0;
   logic [OW-1:0] stall_d;

   task automatic chk(input string nm, input logic [OW-1:0] got,
                      input logic [OW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%b exp=%b", nm, got, exp);
      end
   endtask

   task automatic chki(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
      end
   endtask

   // Matrix s, element (r,c); s=0 is the reference (r*COL+c)<<8.
   function automatic logic [W-1:0] elem(input int s, input int r, input int c);
      int v;
      v = ((r * COL + c) << 8) ^ (s * 'h0135);
      return v[W-1:0];
   endfunction

   function automatic logic [IW-1:0] row_of(input int s, input int r);
      logic [IW-1:0] d;
      for (int c = 0; c < COL; c++) d[c*W +: W] = elem(s, r, c);
      return d;
   endfunction

   function automatic logic [OW-1:0] model_beat(input int s, input int k);
      logic [OW-1:0] b;
      int blk, r, c;
      b = '0;
      for (int l = 0; l < NC; l++) begin
         for (int e = 0; e < CH; e++) begin
            blk = k * NC + l;
            r   = (blk / (COL / BS)) * BS + e / BS;
            c   = (blk % (COL / BS)) * BS + e % BS;
            b[(l*CH+e)*W +: W] = elem(s, r, c);
         end
      end
      return b;
   endfunction

   // Compare process: every cycle outside reset.
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         exp_q.delete();
         exp_done = 0;
         stall    = 0;
      end else begin
         chk1("done", done, exp_done);
         if (done) done_cnt++;
         exp_done = 0;
         if (!en) begin
            chk1("gap_in_ready", in_ready, 1'b0);
            chk1("gap_out_valid", out_valid, 1'b0);
         end
         if (stall && out_valid) chk("stall_hold", out_data, stall_d);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat got=%h", out_data);
            end else begin
               chk("beat", out_data, exp_q[0].d);
               exp_done = exp_q[0].last;
               void'(exp_q.pop_front());
            end
            beats_seen++;
            log_d.push_back(out_data);
            log_c.push_back(cyc);
         end
         stall   = out_valid && !out_ready;
         stall_d = out_data;
      end
   end

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (or_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = 1'b0;
         endcase
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog");
      $fatal(1);
   end

   task automatic send_matrix(input int s, input int gap_row, input bit junk);
      int  n;
      bit  ok;
      for (int r = 0; r < ROW; r++) begin
         if (r == gap_row) begin
            en       = 1'b0;
            in_valid = 1'b1;
            in_data  = ~row_of(s, r);
            repeat (3) @(posedge clk);
            #1;
            en = 1'b1;
         end
         in_valid = 1'b1;
         in_data  = row_of(s, r);
         n  = 0;
         ok = 0;
         while (!ok && n < 100) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
         end
         if (!ok) begin
            checks++;
            errors++;
            $display("FAIL fill_timeout row=%0d", r);
            in_valid = 1'b0;
            return;
         end
      end
      last_acc = cyc;
      for (int k = 0; k < BEATS; k++)
         exp_q.push_back('{model_beat(s, k), k == BEATS - 1});
      in_valid = junk;
      in_data  = junk ? '1 : '0;
   endtask

   task automatic wait_done(input int target);
      int n;
      n = 0;
      while (done_cnt < target && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk1("done_timeout", done_cnt >= target, 1'b1);
   endtask

   task automatic wait_beats(input int target);
      int n;
      n = 0;
      while (beats_seen < target && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk1("beat_timeout", beats_seen >= target, 1'b1);
   endtask

   task automatic check_reset(input string nm);
      chk1({nm, "_in_ready"}, in_ready, 1'b1);
      chk1({nm, "_out_valid"}, out_valid, 1'b0);
      chk({nm, "_out_data"}, out_data, '0);
      chk1({nm, "_done"}, done, 1'b0);
   endtask

   logic [OW-1:0] lit;
   int base;

   initial begin
      rst      = 1'b1;
      en       = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset("rst_hold");
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_reset("rst_rel");
      @(posedge clk);
      #1;

      // Reference matrix, out_ready held high.
      log_d.delete();
      log_c.delete();
      base = done_cnt;
      send_matrix(0, -1, 0);
      wait_done(base + 1);
      chki("ref_beats", log_d.size(), BEATS);
      if (log_d.size() >= BEATS) begin
         lit = 128'h0900_0800_0300_0200_0700_0600_0100_0000;
         chk("lit_beat0", log_d[0], lit);
         lit = 128'h1300_1200_0D00_0C00_0B00_0A00_0500_0400;
         chk("lit_beat1", log_d[1], lit);
         // blocks 10 (rows 6-7, cols 2-3) and 11 (rows 6-7, cols 4-5)
         lit = 128'h2F00_2E00_2900_2800_2D00_2C00_2700_2600;
         chk("lit_beat5", log_d[5], lit);
         chki("latency", log_c[0], last_acc + 1);
         chki("drain_len", log_c[5] - log_c[0], BEATS - 1);
      end

      // out_ready toggling each cycle.
      log_d.delete();
      base = done_cnt;
      or_mode = 1;
      send_matrix(1, -1, 0);
      wait_done(base + 1);
      or_mode = 0;
      chki("tog_beats", log_d.size(), BEATS);

      // en gaps in FILL and DRAIN.
      log_d.delete();
      base = done_cnt;
      send_matrix(2, 3, 0);
      wait_beats(beats_seen + 2);
      en = 1'b0;
      repeat (3) @(posedge clk);
      #1 en = 1'b1;
      wait_done(base + 1);
      chki("gap_beats", log_d.size(), BEATS);

      // Reset after two beats, then a fresh matrix.
      base = beats_seen;
      send_matrix(3, -1, 0);
      wait_beats(base + 2);
      rst = 1'b1;
      @(negedge clk);
      check_reset("mid_rst");
      @(posedge clk);
      #1 rst = 1'b0;
      log_d.delete();
      base = done_cnt;
      send_matrix(4, -1, 0);
      wait_done(base + 1);
      chki("post_rst_beats", log_d.size(), BEATS);
      if (log_d.size() > 0) chk("post_rst_beat0", log_d[0], model_beat(4, 0));

`ifndef R2B_DBUF_EN
      // in_valid held high with junk through DRAIN.
      base = done_cnt;
      send_matrix(5, -1, 1);
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (done) break;
         chk1("drain_in_ready", in_ready, 1'b0);
      end
      in_valid = 1'b0;
      in_data  = '0;
      wait_done(base + 1);
      log_d.delete();
      base = done_cnt;
      send_matrix(6, -1, 0);
      wait_done(base + 1);
      chki("after_junk_beats", log_d.size(), BEATS);
`else
      // Two matrices buffered while output stalls, then drained back to back.
      or_mode = 2;
      @(posedge clk);
      #1;
      base = done_cnt;
      send_matrix(7, -1, 0);
      send_matrix(8, -1, 0);
      @(negedge clk);
      chk1("both_full_in_ready", in_ready, 1'b0);
      @(posedge clk);
      #1;
      log_d.delete();
      log_c.delete();
      or_mode = 0;
      wait_done(base + 2);
      chki("dbuf_beats", log_d.size(), 2 * BEATS);
      for (int i = 1; i < log_c.size(); i++)
         chki("dbuf_no_gap", log_c[i], log_c[i-1] + 1);
`endif

      repeat (3) @(posedge clk);
      chki("queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
